// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - RV32I fetch controller: one outstanding imem read, redirect/squash, decode handshake.
// Optional FETCH_MISALIGN_CHECK_EN: registered one-cycle misalign_err pulse on misaligned redirect targets.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] out_addr, out_addr_n;
    logic        squash, squash_n;
    logic        inst_valid_n;
    logic [31:0] inst_data_n, inst_pc_n;

    logic        redir;
    logic [31:0] redir_sel;
    logic [31:0] redir_pc;
    logic        req_fire;

    // jump wins over branch_taken when both fire together
    assign redir     = jump | branch_taken;
    assign redir_sel = jump ? jump_target : branch_target;
    assign redir_pc  = redir_sel & 32'hFFFF_FFFC;

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        out_addr_n   = out_addr;
        squash_n     = squash;
        inst_valid_n = inst_valid;
        inst_data_n  = inst_data;
        inst_pc_n    = inst_pc;
        case (state)
            IDLE: begin
                state_n = REQ;
                if (redir) fetch_pc_n = redir_pc;
            end
            REQ: begin
                if (req_fire) begin
                    out_addr_n = fetch_pc;
                    fetch_pc_n = fetch_pc + 32'd4;
                    state_n    = WAIT;
                end
                if (redir) begin
                    fetch_pc_n = redir_pc;
                    if (req_fire) squash_n = 1'b1;
                end
            end
            WAIT: begin
                if (redir) begin
                    fetch_pc_n = redir_pc;
                    squash_n   = 1'b1;
                    // a coincident response belongs to the old path and is consumed here
                    if (imem_rsp_valid) begin
                        squash_n = 1'b0;
                        state_n  = REQ;
                    end
                end else if (imem_rsp_valid) begin
                    if (squash) begin
                        squash_n = 1'b0;
                        state_n  = REQ;
                    end else begin
                        inst_data_n  = imem_rsp_data;
                        inst_pc_n    = out_addr;
                        inst_valid_n = 1'b1;
                        state_n      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    inst_valid_n = 1'b0;
                    fetch_pc_n   = redir_pc;
                    state_n      = REQ;
                end else if (inst_ready) begin
                    inst_valid_n = 1'b0;
                    state_n      = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            out_addr   <= 32'h0;
            squash     <= 1'b0;
            inst_valid <= 1'b0;
            inst_data  <= 32'h0;
            inst_pc    <= 32'h0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            out_addr   <= out_addr_n;
            squash     <= squash_n;
            inst_valid <= inst_valid_n;
            inst_data  <= inst_data_n;
            inst_pc    <= inst_pc_n;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_err <= 1'b0;
        else        misalign_err <= redir & (redir_sel[1:0] != 2'b00);
    end
`else
    assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a memory model and a reference instruction-stream model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        jump, branch_taken;
    logic [31:0] jump_target, branch_target;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        misalign_err;

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken), .branch_target(branch_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // reference model: the stream decode must see is pc, pc+4, ... restarting at each redirect target
    typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] model_pc;

    function automatic void model_refill();
        if (exp_q.size() == 0) begin
            exp_q.push_back('{model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void model_restart(input logic [31:0] t);
        exp_q.delete();
        model_pc = t & 32'hFFFF_FFFC;
        model_refill();
    endfunction

    bit          in_reset = 1'b1;
    bit          random_mode = 1'b0;
    bit          phase1 = 1'b1;
    int          lat_fixed = 0;
    bit          mem_fire = 1'b0, mem_busy = 1'b0;
    logic [31:0] mem_fire_addr, mem_addr;
    int          mem_cnt = 0;
    bit          redir_pending = 1'b0;
    logic [31:0] redir_tgt;
    logic [31:0] last_fire_addr = 32'h0;
    int          fire_count = 0;
    bit          held = 1'b0;
    logic [31:0] held_pc, held_data;
    logic        exp_mis = 1'b0;
    int          cycle = 0, last_hs = -1, hs_count = 0, idle_cycles = 0;

    // monitor: samples at negedge, i.e. the values the DUT sees at the next rising edge
    always @(negedge clk) begin
        if (!in_reset) begin
            exp_t e;
            logic [31:0] sel;
            cycle++;
            idle_cycles++;
            if (inst_valid && inst_ready) begin
                idle_cycles = 0;
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_inst_pc", inst_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_data", inst_data, e.data);
                end
                if (phase1 && last_hs >= 0) check("inst_spacing", cycle - last_hs, 3);
                last_hs = cycle;
            end
            if (inst_valid) check("req_while_held", {31'h0, imem_req_valid}, 32'h0);
            if (held) begin
                check("hold_valid", {31'h0, inst_valid}, 32'h1);
                check("hold_pc", inst_pc, held_pc);
                check("hold_data", inst_data, held_data);
            end
            held      = inst_valid && !inst_ready && !(jump || branch_taken);
            held_pc   = inst_pc;
            held_data = inst_data;
            check("misalign_err", {31'h0, misalign_err}, {31'h0, exp_mis});
            sel = jump ? jump_target : branch_target;
`ifdef FETCH_MISALIGN_CHECK_EN
            exp_mis = (jump || branch_taken) && (sel[1:0] != 2'b00);
`else
            exp_mis = 1'b0;
`endif
            redir_pending = jump || branch_taken;
            redir_tgt     = sel;
            mem_fire      = imem_req_valid && imem_req_ready;
            mem_fire_addr = imem_req_addr;
            if (mem_fire) begin
                check("req_aligned", {30'h0, imem_req_addr[1:0]}, 32'h0);
                if (mem_busy) check("req_while_outstanding", 32'h1, 32'h0);
                last_fire_addr = imem_req_addr;
                fire_count++;
            end
            if (idle_cycles > 300) begin
                fail_now("progress_watchdog");
                idle_cycles = 0;
            end
        end
    end

    function automatic logic [31:0] rnd_tgt();
        case ($urandom % 6)
            0: return 32'h0000_0100;
            1: return 32'h0000_0200;
            2: return 32'h0000_0102;
            3: return 32'hFFFF_FFF8;
            4: return 32'h0000_0301;
            default: return $urandom & 32'h0000_FFFF;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (redir_pending) begin
            model_restart(redir_tgt);
            redir_pending = 1'b0;
        end
        model_refill();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_fire) begin
            mem_busy = 1'b1;
            mem_addr = mem_fire_addr;
            mem_cnt  = random_mode ? int'($urandom_range(0, 3)) : lat_fixed;
            mem_fire = 1'b0;
        end
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (random_mode) begin
            int r;
            r = int'($urandom % 16);
            imem_req_ready = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 3) != 0;
            jump           = (r == 0) || (r == 2);
            branch_taken   = (r == 1) || (r == 2);
            jump_target    = rnd_tgt();
            branch_target  = rnd_tgt();
        end else begin
            imem_req_ready = 1'b1;
            inst_ready     = 1'b1;
            jump           = 1'b0;
            branch_taken   = 1'b0;
        end
    endtask

    task automatic wait_fire(input string name, input logic [31:0] exp);
        int n, t;
        n = fire_count;
        t = 0;
        while (fire_count == n && t < 60) begin
            step();
            t++;
        end
        if (fire_count == n) fail_now(name);
        else check(name, last_fire_addr, exp);
    endtask

    task automatic wait_inst();
        int t = 0;
        while (!inst_valid && t < 60) begin
            step();
            t++;
        end
        if (!inst_valid) fail_now("wait_inst_valid");
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!mem_busy && t < 60) begin
            step();
            t++;
        end
        if (!mem_busy) fail_now("wait_outstanding");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        check({tag, "_req_addr"}, imem_req_addr, 32'h0);
        check({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        check({tag, "_inst_data"}, inst_data, 32'h0);
        check({tag, "_inst_pc"}, inst_pc, 32'h0);
        check({tag, "_misalign"}, {31'h0, misalign_err}, 32'h0);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        model_pc = 32'h0;
        model_refill();
        mem_fire = 1'b0;
        mem_busy = 1'b0;
        redir_pending = 1'b0;
        held = 1'b0;
        exp_mis = 1'b0;
        idle_cycles = 0;
        reset = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        jump = 1'b0;
        branch_taken = 1'b0;
        jump_target = 32'h0;
        branch_target = 32'h0;
        inst_ready = 1'b1;
        #2;
        check_reset_outputs("por");
        release_reset();

        @(negedge clk);
        check("first_cycle_idle", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
        check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("first_req_addr", imem_req_addr, 32'h0);
        while (hs_count < 3 && cycle < 60) step();
        if (hs_count < 3) fail_now("phase1_stream");
        phase1 = 1'b0;

        wait_inst();
        for (int i = 0; i < 5; i++) begin
            inst_ready = 1'b0;
            step();
        end
        inst_ready = 1'b0;
        step();

        lat_fixed = 3;
        wait_busy();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0100;
        wait_fire("branch_in_wait_addr", 32'h0000_0100);

        lat_fixed = 0;
        wait_inst();
        jump = 1'b1;
        jump_target = 32'h0000_0200;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0300;
        inst_ready = 1'b0;
        wait_fire("jump_over_branch_addr", 32'h0000_0200);

        wait_inst();
        jump = 1'b1;
        jump_target = 32'hFFFF_FFF8;
        wait_fire("wrap_pre_addr", 32'hFFFF_FFF8);
        wait_fire("wrap_last_addr", 32'hFFFF_FFFC);
        wait_fire("wrap_zero_addr", 32'h0000_0000);

        wait_inst();
        jump = 1'b1;
        jump_target = 32'h0000_0102;
        wait_fire("misaligned_jump_addr", 32'h0000_0100);
        repeat (8) step();

        random_mode = 1'b1;
        repeat (3000) step();

        random_mode = 1'b0;
        lat_fixed = 3;
        wait_busy();
        #2;
        reset = 1'b0;
        in_reset = 1'b1;
        #1;
        check_reset_outputs("mid_wait");
        release_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        lat_fixed = 0;
        hs_count = 0;
        wait_fire("restart_addr", 32'h0000_0000);
        random_mode = 1'b1;
        repeat (1500) step();
        random_mode = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch controller that sequences the instruction-memory port for the RV32I core. It owns the fetch PC and issues one outstanding read at a time over a valid/ready request channel. It delivers each returned instruction word with its PC to decode over a valid/ready handshake. Jump and branch redirects from execute are applied here, and any in-flight or held instruction on the wrong path is squashed.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned read address (= fetch_pc)
- imem_rsp_valid  in  1  read data valid (one-cycle pulse per accepted request)
- imem_rsp_data  in  32  read data
- jump  in  1  jump redirect, 1-cycle pulse
- jump_target  in  32  jump destination
- branch_taken  in  1  taken-branch redirect, 1-cycle pulse
- branch_target  in  32  branch destination
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  32  instruction word
- inst_pc  out  32  PC of inst_data
- misalign_err  out  1  misaligned redirect target flag (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, HOLD. Internal: fetch_pc[31:0], out_addr[31:0] (address of accepted request), squash (1 bit).
- IDLE: entered only from reset; next cycle goes to REQ.
- REQ: imem_req_valid=1, imem_req_addr=fetch_pc. On imem_req_valid && imem_req_ready: out_addr<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), go to WAIT.
- WAIT: on imem_rsp_valid: if squash, discard, clear squash, go to REQ. Otherwise inst_data<=imem_rsp_data, inst_pc<=out_addr, inst_valid<=1, go to HOLD.
- HOLD: on inst_valid && inst_ready: inst_valid<=0, go to REQ.
- Redirect: jump has priority over branch_taken. Both high uses jump_target. Target used is {target[31:2],2'b00}. Effects per state:
  - IDLE: fetch_pc<=target.
  - REQ: fetch_pc<=target. If the request is accepted in the same cycle, go to WAIT with squash<=1. imem_req_addr may change while imem_req_valid stays high; the memory samples only on acceptance.
  - WAIT: squash<=1, fetch_pc<=target. A response arriving in the same cycle is discarded, and the state goes to REQ.
  - HOLD: inst_valid<=0, fetch_pc<=target, go to REQ. A coincident inst_ready handshake completes, and the redirect still applies.
- imem_rsp_valid outside WAIT is ignored.
- Reset, asynchronous at any time including mid-transaction: state=IDLE, fetch_pc=RESET_PC, out_addr=0, squash=0, inst_valid=0, inst_data=0, inst_pc=0, imem_req_valid=0, misalign_err=0. An in-flight response after reset release is ignored because the state is not WAIT.

## Timing
- imem_req_valid, imem_req_addr: combinational from state/fetch_pc (registered sources only, no input-to-output path).
- inst_* and misalign_err are registered.
- First request: the cycle after the first clk edge following reset deassertion.
- Latency: request accepted at edge N, response at edge N+k (k>=1), inst_valid high after edge N+k.
- Minimum per-instruction cycle: 3 clocks with zero-wait memory and inst_ready=1.
- Redirect at edge R: the next request carries the target no later than the cycle after R+1 from REQ, or after the squashed response returns from WAIT.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: misalign_err pulses high for one cycle after any redirect edge whose selected target has [1:0]!=0. The redirect is still taken with the low bits cleared.
- Not defined: misalign_err tied 0, and low target bits are silently cleared.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8, one instruction every 3 cycles.
- inst_ready=0 for 5 cycles in HOLD -> inst_valid held, inst_pc/inst_data stable, no new imem_req_valid.
- branch_taken with branch_target=0x100 while in WAIT for address 0x8 -> response for 0x8 dropped, next request addr 0x100, next inst_pc=0x100.
- jump (target 0x200) and branch_taken (target 0x300) in the same cycle during HOLD -> held instruction dropped, next request addr 0x200.
- fetch_pc=0xFFFF_FFFC -> following request addr 0x0.
- With FETCH_MISALIGN_CHECK_EN, jump_target=0x102 -> misalign_err one-cycle pulse, next request addr 0x100. Reset asserted mid-WAIT -> all outputs 0, restart at RESET_PC.
